debouncer_array: RTL and testbench

Parametrised multi-channel debouncer for push-buttons and switches on the 12 MHz board clock. Each channel gets its own two-flop synchroniser, its own bounce counter and its own hold timer. Outputs per channel are a clean level, single-cycle rise and fall pulses, and a long-press "held" flag. It sits between the raw board pins and any FSM that consumes button events, and replaces the single-channel `debouncer`.

---
 rtl/debouncer_pkg.sv | 17 +
 rtl/debounce_channel.sv | 140 ++++++++++++++
 rtl/debouncer_array.sv | 39 +++
 tb/tb_debouncer_array.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types for the multi-channel debouncer.
// Per-channel FSM state encoding.
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } db_state_t;

  // Width needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: two-flop synchroniser, bounce FSM and counter,
// and a saturating long-press hold timer.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned BOUNCE_TICKS = 100,
  parameter int unsigned HOLD_TICKS   = 12_000_000,
  parameter logic        INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy_in,
  output logic debounced_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic held
);

  localparam int unsigned BW = cnt_width(BOUNCE_TICKS);
  localparam int unsigned HW = cnt_width(HOLD_TICKS);
  localparam logic [BW-1:0] BOUNCE_MAX = BW'(BOUNCE_TICKS);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_sync_in;
  db_state_t     r_state;
  logic [BW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_deb;
  logic          r_rise;
  logic          r_fall;
  logic          r_held;
  logic          w_fall_commit;

  // Reset loads the inversion bit so the post-inversion idle level is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= INVERT;
      r_sync2 <= INVERT;
    end else begin
      r_sync1 <= bouncy_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_in = r_sync2 ^ INVERT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (w_sync_in) begin
            r_state <= PEND_HIGH;
            r_cnt   <= BW'(1);
          end
        end
        PEND_HIGH: begin
          if (!w_sync_in) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == BOUNCE_MAX) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
            r_deb   <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        STABLE_HIGH: begin
          if (!w_sync_in) begin
            r_state <= PEND_LOW;
            r_cnt   <= BW'(1);
          end
        end
        PEND_LOW: begin
          if (w_sync_in) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == BOUNCE_MAX) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= '0;
          r_deb   <= 1'b0;
        end
      endcase
    end
  end

  // Same condition the FSM uses to complete a fall, so held drops with fall_pulse.
  assign w_fall_commit = (r_state == PEND_LOW) && !w_sync_in && (r_cnt == BOUNCE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_held <= 1'b0;
    end else if (!r_deb || w_fall_commit) begin
      r_hold <= '0;
      r_held <= 1'b0;
    end else begin
      if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HW'(1);
      end
      if (r_hold == HOLD_LAST) begin
        r_held <= 1'b1;
      end
    end
  end

  assign debounced_out = r_deb;
  assign rise_pulse    = r_rise;
  assign fall_pulse    = r_fall;
  assign held          = r_held;

  a_no_dual_pulse : assert property (@(posedge clk) disable iff (!rst)
    !(r_rise && r_fall));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
    r_cnt <= BOUNCE_MAX);
  a_hold_bound : assert property (@(posedge clk) disable iff (!rst)
    r_hold <= HOLD_MAX);

endmodule

// File: rtl/debouncer_array.sv
// Multi-channel debouncer: one independent debounce_channel per pin plus
// a combined event flag.
module debouncer_array
  import debouncer_pkg::*;
#(
  parameter int unsigned     N_CH         = 4,
  parameter int unsigned     BOUNCE_TICKS = 100,
  parameter int unsigned     HOLD_TICKS   = 12_000_000,
  parameter logic [N_CH-1:0] INVERT_MASK  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] debounced_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] held,
  output logic            any_event
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .BOUNCE_TICKS (BOUNCE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .INVERT       (INVERT_MASK[g])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .bouncy_in     (bouncy_in[g]),
      .debounced_out (debounced_out[g]),
      .rise_pulse    (rise_pulse[g]),
      .fall_pulse    (fall_pulse[g]),
      .held          (held[g])
    );
  end

  assign any_event = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_debouncer_array.sv
// Directed self-checking bench for debouncer_array
// (N_CH=4, BOUNCE_TICKS=8, HOLD_TICKS=32, ch3 inverted).
module tb_debouncer_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bouncy_in;
  logic [3:0] debounced_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] held;
  logic       any_event;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  debouncer_array #(
    .N_CH         (4),
    .BOUNCE_TICKS (8),
    .HOLD_TICKS   (32),
    .INVERT_MASK  (4'b1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bouncy_in     (bouncy_in),
    .debounced_out (debounced_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .held          (held),
    .any_event     (any_event)
  );

  // Advance n rising edges, leaving time 1 unit past the last one.
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    bouncy_in = 4'b1000;
    step(3);
    n_checks++;
    if ({debounced_out, rise_pulse, fall_pulse, held, any_event} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got deb=%b rise=%b fall=%b held=%b any=%b expected all 0",
               debounced_out, rise_pulse, fall_pulse, held, any_event);
    end
    #3 rst = 1'b1;
    step(15);
    n_checks++;
    if ({debounced_out, rise_pulse, fall_pulse, held, any_event} !== 17'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got deb=%b rise=%b fall=%b held=%b any=%b expected all 0",
               debounced_out, rise_pulse, fall_pulse, held, any_event);
    end
  endtask

  task automatic test_clean_step;
    bouncy_in[0] = 1'b1;
    step(10);
    n_checks++;
    if (debounced_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL step_early: got deb=%b rise=%b expected deb0=0 rise0=0",
               debounced_out, rise_pulse);
    end
    step(1);
    n_checks++;
    if (debounced_out[0] !== 1'b1 || rise_pulse !== 4'b0001 || any_event !== 1'b1) begin
      n_fail++;
      $display("FAIL step_rise: got deb=%b rise=%b any=%b expected deb0=1 rise=0001 any=1",
               debounced_out, rise_pulse, any_event);
    end
    step(1);
    n_checks++;
    if (debounced_out[0] !== 1'b1 || rise_pulse !== 4'b0000 || any_event !== 1'b0) begin
      n_fail++;
      $display("FAIL step_one_cycle: got deb=%b rise=%b any=%b expected deb0=1 rise=0000 any=0",
               debounced_out, rise_pulse, any_event);
    end
    bouncy_in[0] = 1'b0;
    step(12);
    n_checks++;
    if (debounced_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL step_release: got deb=%b expected deb0=0", debounced_out);
    end
  endtask

  task automatic test_bounce;
    int          gaps[14] = '{3, 1, 5, 7, 2, 4, 6, 1, 3, 7, 2, 5, 1, 4};
    int unsigned rises    = 0;
    int unsigned falls    = 0;
    int          rise_at  = -1;
    for (int i = 0; i < 14; i++) begin
      bouncy_in[1] = ~bouncy_in[1];
      for (int j = 0; j < gaps[i]; j++) begin
        step(1);
        rises += rise_pulse[1];
        falls += fall_pulse[1];
      end
    end
    bouncy_in[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (rise_pulse[1]) begin
        rises++;
        rise_at = n - 1;
      end
      falls += fall_pulse[1];
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
    n_checks++;
    if (rise_at != 10) begin
      n_fail++;
      $display("FAIL bounce_rise_time: got edge k+%0d expected edge k+10", rise_at);
    end
    n_checks++;
    if (falls != 0 || debounced_out[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_final: got falls=%0d deb=%b expected falls=0 deb1=1",
               falls, debounced_out);
    end
  endtask

  task automatic test_glitch;
    int unsigned events  = 0;
    int unsigned deb_hi  = 0;
    bouncy_in[2] = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if (n == 5) bouncy_in[2] = 1'b0;
      step(1);
      events += rise_pulse[2] + fall_pulse[2];
      deb_hi += debounced_out[2];
    end
    n_checks++;
    if (events != 0 || deb_hi != 0) begin
      n_fail++;
      $display("FAIL glitch_filtered: got pulses=%0d high_cycles=%0d expected 0 and 0",
               events, deb_hi);
    end
  endtask

  task automatic test_hold;
    bouncy_in[0] = 1'b1;
    step(11);
    n_checks++;
    if (rise_pulse[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_rise: got rise=%b expected rise0=1", rise_pulse);
    end
    step(31);
    n_checks++;
    if (held[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_early: got held=%b at rise+31 expected held0=0", held);
    end
    step(1);
    n_checks++;
    if (held[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_set: got held=%b at rise+32 expected held0=1", held);
    end
    step(8);
    bouncy_in[0] = 1'b0;
    step(10);
    n_checks++;
    if (held[0] !== 1'b1 || fall_pulse[0] !== 1'b0 || debounced_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_pending_low: got held=%b fall=%b deb=%b expected held0=1 fall0=0 deb0=1",
               held, fall_pulse, debounced_out);
    end
    step(1);
    n_checks++;
    if (fall_pulse !== 4'b0001 || held[0] !== 1'b0 || debounced_out[0] !== 1'b0 ||
        any_event !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got fall=%b held=%b deb=%b any=%b expected fall=0001 held0=0 deb0=0 any=1",
               fall_pulse, held, debounced_out, any_event);
    end
    step(2);
  endtask

  task automatic test_invert;
    bouncy_in[3] = 1'b0;
    step(10);
    n_checks++;
    if (rise_pulse[3] !== 1'b0 || debounced_out[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL invert_early: got rise=%b deb=%b expected rise3=0 deb3=0",
               rise_pulse, debounced_out);
    end
    step(1);
    n_checks++;
    if (rise_pulse[3] !== 1'b1 || debounced_out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL invert_rise: got rise=%b deb=%b expected rise3=1 deb3=1",
               rise_pulse, debounced_out);
    end
    bouncy_in[3] = 1'b1;
    step(12);
    n_checks++;
    if (debounced_out[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL invert_release: got deb=%b expected deb3=0", debounced_out);
    end
  endtask

  task automatic test_reset_mid_pending;
    bouncy_in[0] = 1'b1;
    step(6);
    n_checks++;
    if (debounced_out !== 4'b0010 || held[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got deb=%b held=%b expected deb=0010 held1=1",
               debounced_out, held);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({debounced_out, rise_pulse, fall_pulse, held, any_event} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset: got deb=%b rise=%b fall=%b held=%b any=%b expected all 0",
               debounced_out, rise_pulse, fall_pulse, held, any_event);
    end
    step(2);
    #3 rst = 1'b1;
    step(10);
    n_checks++;
    if (rise_pulse !== 4'b0000 || debounced_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_early: got rise=%b deb=%b expected 0000 0000",
               rise_pulse, debounced_out);
    end
    step(1);
    n_checks++;
    if (rise_pulse !== 4'b0011 || debounced_out !== 4'b0011 || any_event !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_rise: got rise=%b deb=%b any=%b expected rise=0011 deb=0011 any=1",
               rise_pulse, debounced_out, any_event);
    end
    step(1);
    n_checks++;
    if (rise_pulse !== 4'b0000 || any_event !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_single: got rise=%b any=%b expected rise=0000 any=0",
               rise_pulse, any_event);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_hold();
    test_invert();
    test_reset_mid_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
